cond_fork4_sched: RTL

- Synchronous scheduler that sequences a 4-way conditional fork stage of the micropipeline.
- Accepts route requests, each a 4-bit destination mask, and holds the mask as the fork's per-branch valid lines.
- Fires a one-cycle drive only when every selected branch has a free slot.
- Tracks outstanding tokens per branch with credit counters, replenished by per-branch free pulses.
- Sits between the request source (descriptor logic) and the fork's drive/valid inputs; per-branch free pulses are returned from the downstream stages.

---
 rtl/cond_fork4_sched.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cond_fork4_sched.sv
// Scheduler for a 4-way conditional fork: holds a destination mask
// on the branch valids and fires one drive once every branch has credit.
module cond_fork4_sched #(
  parameter int CREDITS = 2,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic [3:0] i_req_mask,
  output logic       o_drive,
  output logic [3:0] o_valid,
  input  logic [3:0] i_free,
  output logic [3:0] o_credit_empty,
  output logic       o_busy,
  output logic [3:0] o_err,
  output logic [7:0] o_drop_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FIRE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] C_MAX = CW'(CREDITS);

  state_t                r_state;
  state_t                w_nxt;
  logic [3:0]            r_mask;
  logic [3:0]            r_valid;
  logic [3:0][CW-1:0]    r_cred;
  logic [3:0]            r_err;
  logic [7:0]            r_drop;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_fire;
  logic                  w_ok;
  logic [3:0]            w_empty;

  // Credit-zero flags straight from the credit registers
  always_comb begin
    w_empty = '0;
    for (int j = 0; j < 4; j++) begin
      w_empty[j] = (r_cred[j] == '0);
    end
  end

  assign w_ok = &(~r_mask | ~w_empty);

  // Next-state and handshake decode
  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_drop   = 1'b0;
    w_fire   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_req_valid && (i_req_mask != 4'd0)) begin
          w_accept = 1'b1;
          w_nxt    = SETUP;
        end else if (i_req_valid) begin
          w_drop = 1'b1;
        end
      end
      SETUP: begin
        if (w_ok) w_nxt = FIRE;
      end
      FIRE: begin
        w_fire = 1'b1;
        w_nxt  = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  // State, held mask and registered branch valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_accept) begin
        r_mask  <= i_req_mask;
        r_valid <= i_req_mask;
      end else if (w_fire) begin
        r_mask  <= '0;
        r_valid <= '0;
      end
    end
  end

  // Per-branch credit counters and sticky overflow errors
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < 4; j++) r_cred[j] <= C_MAX;
      r_err <= '0;
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (w_fire && r_mask[j] && !i_free[j]) begin
          r_cred[j] <= r_cred[j] - 1'b1;
        end else if (i_free[j] && !(w_fire && r_mask[j])) begin
          if (r_cred[j] == C_MAX) r_err[j] <= 1'b1;
          else r_cred[j] <= r_cred[j] + 1'b1;
        end
      end
    end
  end

  // Saturating count of zero-mask requests
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop <= '0;
    end else if (w_drop && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign o_req_ready    = (r_state == IDLE);
  assign o_busy         = (r_state != IDLE);
  assign o_drive        = (r_state == FIRE);
  assign o_valid        = r_valid;
  assign o_credit_empty = w_empty;
  assign o_err          = r_err;
  assign o_drop_cnt     = r_drop;

endmodule
